ddr3_cmd_responder: RTL and testbench
=====================================

DDR3_CMD_RESPONDER -- requirements
Module: ddr3_cmd_responder

Interface
REQ-001 Parameter CL, default 5: read latency in CLK cycles, legal range 2..15.
REQ-002 Parameter TRFC, default 10: refresh busy cycles, legal range 2..255.
REQ-003 Port CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port RESET  input  1  asynchronous, active-high reset.
REQ-005 Ports CS, RAS, CAS, WE  input  1 each  active-low command strobes, sampled every edge.
REQ-006 Port Addr_in  input  15  row address on ACT; column on RD/WR; A[10] = auto-precharge / all-banks flag.
REQ-007 Port BA_in  input  3  bank address.
REQ-008 Ports DQ_in  input  16, LDM and UDM  input  1 each: write data and byte masks, sampled with the WR command; mask=1 means byte not written.
REQ-009 Port DQ_rd  output  16  read data.
REQ-010 Port DQ_rd_valid  output  1  one-cycle strobe qualifying DQ_rd.
REQ-011 Port bank_open  output  8  bit b=1 means bank b has an open row.
REQ-012 Port ready  output  1  ZQCL has been seen and no refresh is in progress.
REQ-013 Port refresh_busy  output  1  high while a refresh is in progress.
REQ-014 Port err_valid  output  1  one-cycle error pulse; err_code  output  3  error cause; err_count  output  8  saturating error total.

Function
REQ-015 Command decode on {CS,RAS,CAS,WE}: 1xxx DESELECT; 0111 NOP; 0011 ACT; 0101 WR; 0110 RD; 0010 PRE; 0001 REF; 0000 MRS; 0100 ZQCL. DESELECT and NOP have no effect.
REQ-016 Controller FSM states: INIT, READY, REFRESHING.
REQ-017 INIT: ZQCL moves the FSM to READY on the next edge; MRS is accepted and has no effect; any other command sets err_code 5 and is ignored.
REQ-018 READY, ACT: bank closed -> opens the bank and latches Addr_in as its row. Bank already open -> err_code 1, row unchanged.
REQ-019 READY, WR/RD to an open bank: storage index = {BA_in, Addr_in[4:0]} into a 256x16 array.
REQ-020 WR: writes each byte whose mask is 0 in the same edge.
REQ-021 RD: snapshots the array word at the command edge; DQ_rd_valid=1 with that data exactly CL edges later. Implemented as a CL-deep pipeline that accepts back-to-back RDs.
REQ-022 WR/RD with Addr_in[10]=1 closes the bank after the access.
REQ-023 WR/RD to a closed bank -> err_code 2, no array access, no read strobe.
REQ-024 PRE: Addr_in[10]=1 closes all banks; otherwise closes bank BA_in. PRE to a closed bank is legal and has no effect.
REQ-025 REF with all banks closed -> REFRESHING with an internal counter of TRFC. REF with any bank open -> err_code 3, ignored.
REQ-026 REFRESHING: refresh_busy=1 for exactly TRFC cycles, then the FSM returns to READY. Any non-NOP/non-DESELECT command -> err_code 4, ignored.
REQ-027 ZQCL or MRS in READY is accepted and has no effect.
REQ-028 Error outputs are registered: err_valid is asserted the edge after the offending command; err_count increments and saturates at 255.
REQ-029 The read pipeline keeps draining during REFRESHING.

Reset
REQ-030 RESET=1 asynchronously forces: FSM=INIT, bank_open=0, all row registers=0, read pipeline cleared, DQ_rd=0, DQ_rd_valid=0, ready=0, refresh_busy=0, err_valid=0, err_code=0, err_count=0.
REQ-031 Array contents are not reset.
REQ-032 Reset asserted mid-read or mid-refresh drops the in-flight work; no strobe follows the release of reset.

Structure
REQ-033 A shared package holds: command encodings, FSM state encodings, error-code constants, and CL/TRFC defaults.
REQ-034 One sub-module, ddr3_rd_pipe, implements the CL-deep valid/data delay line; all other logic is in the top level.

Verification
REQ-035 Reset, then ZQCL -> ready=1 one edge later. ACT before ZQCL -> err_code 5, err_count 1.
REQ-036 ACT BA=2 row 0x0011; WR col 3 DQ_in=0xA5C3 with LDM=UDM=0; RD col 3 -> DQ_rd=0xA5C3 with DQ_rd_valid exactly 5 edges after RD.
REQ-037 WR 0xFFFF then WR 0x1200 with UDM=1 to the same column; RD -> 0xFF00.
REQ-038 RD with A10=1 -> bank_open[2]=0; a following RD -> err_code 2 and no read strobe.
REQ-039 REF with a bank open -> err_code 3. PRE A10=1, then REF -> refresh_busy=1 for 10 cycles; ACT issued during that window -> err_code 4.
REQ-040 Four back-to-back RDs -> four consecutive valid strobes. RESET asserted after the second RD -> no further strobes after reset release.

Source files
------------

// File: rtl/ddr3_cmd_responder_pkg.sv
// Shared definitions for the DDR3 command responder: command encodings,
// controller state encodings, error causes and parameter defaults.
package ddr3_cmd_responder_pkg;

  // Default read latency and refresh busy time, in CLK cycles
  localparam int CL_DEFAULT   = 5;
  localparam int TRFC_DEFAULT = 10;

  // Commands as {CS, RAS, CAS, WE}; strobes are active-low
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0101;
  localparam logic [3:0] CMD_RD   = 4'b0110;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0100;

  // Controller states
  localparam logic [1:0] ST_INIT       = 2'd0;
  localparam logic [1:0] ST_READY      = 2'd1;
  localparam logic [1:0] ST_REFRESHING = 2'd2;

  // Error causes reported on err_code
  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN    = 3'd1;
  localparam logic [2:0] ERR_BANK_CLOSED = 3'd2;
  localparam logic [2:0] ERR_REF_OPEN    = 3'd3;
  localparam logic [2:0] ERR_REF_BUSY    = 3'd4;
  localparam logic [2:0] ERR_NOT_INIT    = 3'd5;

  // A deselected device sees the same thing as a NOP, so fold DESELECT into NOP
  function automatic logic [3:0] decode_cmd(input logic cs, input logic ras,
                                            input logic cas, input logic we);
    return cs ? CMD_NOP : {1'b0, ras, cas, we};
  endfunction

endpackage

// File: rtl/ddr3_cmd_responder_rd_pipe.sv
// Read-return delay line: a read accepted on one edge reappears as a
// one-cycle strobe with its data DEPTH edges later. Back-to-back reads
// simply occupy consecutive stages.
module ddr3_rd_pipe #(
  parameter int DEPTH = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        out_valid,
  output logic [15:0] out_data
);

  logic [DEPTH-1:0] stage_valid;
  logic [15:0]      stage_data [DEPTH];

  // Shift every stage one step per edge; the output register adds the final edge of latency
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stage_valid <= '0;
      for (int i = 0; i < DEPTH; i++) stage_data[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      stage_valid[0] <= in_valid;
      stage_data[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
      out_valid <= stage_valid[DEPTH-1];
      out_data  <= stage_valid[DEPTH-1] ? stage_data[DEPTH-1] : 16'h0000;
    end
  end

endmodule

// File: rtl/ddr3_cmd_responder.sv
// Behavioural DDR3 command responder: decodes the command strobes, tracks
// open banks, services reads/writes against a small 256x16 store, runs
// refresh timing and reports protocol errors.
module ddr3_cmd_responder
  import ddr3_cmd_responder_pkg::*;
#(
  parameter int CL   = CL_DEFAULT,
  parameter int TRFC = TRFC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [14:0] Addr_in,
  input  logic [2:0]  BA_in,
  input  logic [15:0] DQ_in,
  input  logic        LDM,
  input  logic        UDM,
  output logic [15:0] DQ_rd,
  output logic        DQ_rd_valid,
  output logic [7:0]  bank_open,
  output logic        ready,
  output logic        refresh_busy,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [7:0]  err_count
);

  localparam logic [7:0] TRFC_CNT = 8'(TRFC);

  logic [1:0]  state;
  logic [7:0]  ref_cnt;
  logic [14:0] row_addr [8];
  logic [15:0] mem [256];

  logic [3:0]  cmd;
  logic [7:0]  mem_idx;
  logic        wr_fire;
  logic        rd_fire;
  logic        err_hit;
  logic [2:0]  err_next;

  assign cmd          = decode_cmd(CS, RAS, CAS, WE);
  assign mem_idx      = {BA_in, Addr_in[4:0]};
  assign ready        = (state == ST_READY);
  assign refresh_busy = (state == ST_REFRESHING);

  // Classify the current command: does it touch the array, and is it an error in this state
  always_comb begin
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    err_hit  = 1'b0;
    err_next = ERR_NONE;
    case (state)
      ST_INIT: begin
        if (cmd != CMD_NOP && cmd != CMD_MRS && cmd != CMD_ZQCL) begin
          err_hit  = 1'b1;
          err_next = ERR_NOT_INIT;
        end
      end
      ST_READY: begin
        case (cmd)
          CMD_ACT: begin
            if (bank_open[BA_in]) begin
              err_hit  = 1'b1;
              err_next = ERR_ACT_OPEN;
            end
          end
          CMD_WR, CMD_RD: begin
            if (bank_open[BA_in]) begin
              wr_fire = (cmd == CMD_WR);
              rd_fire = (cmd == CMD_RD);
            end else begin
              err_hit  = 1'b1;
              err_next = ERR_BANK_CLOSED;
            end
          end
          CMD_REF: begin
            if (|bank_open) begin
              err_hit  = 1'b1;
              err_next = ERR_REF_OPEN;
            end
          end
          default: ;
        endcase
      end
      ST_REFRESHING: begin
        if (cmd != CMD_NOP) begin
          err_hit  = 1'b1;
          err_next = ERR_REF_BUSY;
        end
      end
      default: ;
    endcase
  end

  // Controller state, refresh countdown, open-bank bitmap and per-bank row registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_INIT;
      ref_cnt   <= '0;
      bank_open <= '0;
      for (int b = 0; b < 8; b++) row_addr[b] <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cmd == CMD_ZQCL) state <= ST_READY;
        end
        ST_READY: begin
          case (cmd)
            CMD_ACT: begin
              if (!bank_open[BA_in]) begin
                bank_open[BA_in] <= 1'b1;
                row_addr[BA_in]  <= Addr_in;
              end
            end
            CMD_WR, CMD_RD: begin
              if ((wr_fire || rd_fire) && Addr_in[10]) bank_open[BA_in] <= 1'b0;
            end
            CMD_PRE: begin
              if (Addr_in[10]) bank_open <= '0;
              else             bank_open[BA_in] <= 1'b0;
            end
            CMD_REF: begin
              if (!(|bank_open)) begin
                state   <= ST_REFRESHING;
                ref_cnt <= TRFC_CNT;
              end
            end
            default: ;
          endcase
        end
        ST_REFRESHING: begin
          if (ref_cnt <= 8'd1) state <= ST_READY;
          else                 ref_cnt <= ref_cnt - 8'd1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Registered error reporting: one-cycle pulse, sticky cause, saturating total
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_count <= '0;
    end else begin
      err_valid <= err_hit;
      if (err_hit) begin
        err_code <= err_next;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

  // Byte-masked write into the store; contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      if (!LDM) mem[mem_idx][7:0]  <= DQ_in[7:0];
      if (!UDM) mem[mem_idx][15:8] <= DQ_in[15:8];
    end
  end

  // The read word is snapshotted on the command edge and carried through the delay line
  ddr3_rd_pipe #(
    .DEPTH (CL)
  ) u_rd_pipe (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (rd_fire),
    .in_data   (mem[mem_idx]),
    .out_valid (DQ_rd_valid),
    .out_data  (DQ_rd)
  );

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Self-checking bench for ddr3_cmd_responder: directed scenarios with
// hand-computed expectations, then randomized command traffic compared
// every cycle against a behavioural model of the command rules.
module tb_ddr3_cmd_responder;

  localparam int CL   = 5;
  localparam int TRFC = 10;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_DES  = 4'b1111;
  localparam logic [3:0] C_ACT  = 4'b0011;
  localparam logic [3:0] C_WR   = 4'b0101;
  localparam logic [3:0] C_RD   = 4'b0110;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_REF  = 4'b0001;
  localparam logic [3:0] C_MRS  = 4'b0000;
  localparam logic [3:0] C_ZQCL = 4'b0100;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CS = 1'b1, RAS = 1'b1, CAS = 1'b1, WE = 1'b1;
  logic [14:0] Addr_in = '0;
  logic [2:0]  BA_in = '0;
  logic [15:0] DQ_in = '0;
  logic        LDM = 1'b0, UDM = 1'b0;
  logic [15:0] DQ_rd;
  logic        DQ_rd_valid;
  logic [7:0]  bank_open;
  logic        ready;
  logic        refresh_busy;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [7:0]  err_count;

  ddr3_cmd_responder #(
    .CL   (CL),
    .TRFC (TRFC)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CS           (CS),
    .RAS          (RAS),
    .CAS          (CAS),
    .WE           (WE),
    .Addr_in      (Addr_in),
    .BA_in        (BA_in),
    .DQ_in        (DQ_in),
    .LDM          (LDM),
    .UDM          (UDM),
    .DQ_rd        (DQ_rd),
    .DQ_rd_valid  (DQ_rd_valid),
    .bank_open    (bank_open),
    .ready        (ready),
    .refresh_busy (refresh_busy),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .err_count    (err_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: what the outputs must be after edge number cyc
  int          cyc;
  bit          zq_seen;
  bit          in_refresh;
  int          ref_end;
  logic [7:0]  m_bank;
  logic [15:0] m_mem [256];
  logic [1:0]  m_known [256];
  logic [16:0] rd_due [int];
  bit          m_err_valid;
  logic [2:0]  m_err_code;
  int          m_err_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
  endtask

  function automatic bit refreshingNow();
    return in_refresh && (cyc < ref_end);
  endfunction

  task automatic modelReset();
    zq_seen     = 1'b0;
    in_refresh  = 1'b0;
    ref_end     = 0;
    m_bank      = '0;
    rd_due.delete();
    m_err_valid = 1'b0;
    m_err_code  = 3'd0;
    m_err_count = 0;
  endtask

  task automatic flagError(input int code);
    m_err_valid = 1'b1;
    m_err_code  = 3'(code);
    if (m_err_count < 255) m_err_count++;
  endtask

  // Apply the command rules for the edge about to happen
  task automatic modelStep(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a,
                           input logic [15:0] dq, input logic lm, input logic um);
    int k;
    bit busy;
    int idx;
    k    = cyc + 1;
    busy = refreshingNow();
    idx  = {ba, a[4:0]};
    m_err_valid = 1'b0;
    if (c[3] || c == C_NOP) begin
    end else if (!zq_seen) begin
      if (c == C_ZQCL) zq_seen = 1'b1;
      else if (c != C_MRS) flagError(5);
    end else if (busy) begin
      flagError(4);
    end else begin
      case (c)
        C_ACT: if (m_bank[ba]) flagError(1); else m_bank[ba] = 1'b1;
        C_WR: begin
          if (!m_bank[ba]) flagError(2);
          else begin
            if (!lm) begin m_mem[idx][7:0]  = dq[7:0];  m_known[idx][0] = 1'b1; end
            if (!um) begin m_mem[idx][15:8] = dq[15:8]; m_known[idx][1] = 1'b1; end
            if (a[10]) m_bank[ba] = 1'b0;
          end
        end
        C_RD: begin
          if (!m_bank[ba]) flagError(2);
          else begin
            rd_due[k + CL] = {m_known[idx] == 2'b11, m_mem[idx]};
            if (a[10]) m_bank[ba] = 1'b0;
          end
        end
        C_PRE: if (a[10]) m_bank = '0; else m_bank[ba] = 1'b0;
        C_REF: begin
          if (m_bank != 8'h00) flagError(3);
          else begin
            in_refresh = 1'b1;
            ref_end    = k + TRFC;
          end
        end
        default: ;
      endcase
    end
    cyc = k;
  endtask

  // Compare every DUT output against the model
  task automatic checkOutput();
    bit exp_v;
    check("ready", 32'(ready), 32'(zq_seen && !refreshingNow()));
    check("refresh_busy", 32'(refresh_busy), 32'(refreshingNow()));
    check("bank_open", 32'(bank_open), 32'(m_bank));
    check("err_valid", 32'(err_valid), 32'(m_err_valid));
    check("err_code", 32'(err_code), 32'(m_err_code));
    check("err_count", 32'(err_count), 32'(m_err_count));
    exp_v = rd_due.exists(cyc) != 0;
    check("rd_valid", 32'(DQ_rd_valid), 32'(exp_v));
    if (exp_v) begin
      if (rd_due[cyc][16]) check("rd_data", 32'(DQ_rd), 32'(rd_due[cyc][15:0]));
      rd_due.delete(cyc);
    end
  endtask

  // Drive one command at a falling edge, advance the model, check after the rising edge
  task automatic applyStimulus(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a,
                               input logic [15:0] dq, input logic lm, input logic um);
    {CS, RAS, CAS, WE} = c;
    BA_in   = ba;
    Addr_in = a;
    DQ_in   = dq;
    LDM     = lm;
    UDM     = um;
    modelStep(c, ba, a, dq, lm, um);
    @(negedge CLK);
    checkOutput();
  endtask

  task automatic nop(input int n);
    repeat (n) applyStimulus(C_NOP, 3'd0, 15'd0, 16'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle, held over two edges
  task automatic doReset();
    {CS, RAS, CAS, WE} = C_DES;
    #2;
    RESET = 1'b1;
    modelReset();
    #1;
    check("async_rst_valid", 32'(DQ_rd_valid), 32'd0);
    check("async_rst_ready", 32'(ready), 32'd0);
    check("async_rst_count", 32'(err_count), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    checkOutput();
  endtask

  task automatic randomCycle();
    int r;
    logic [3:0]  c;
    logic [14:0] a;
    r = $urandom_range(0, 99);
    if      (r < 5)  c = C_NOP;
    else if (r < 9)  c = {1'b1, 3'($urandom_range(0, 7))};
    else if (r < 29) c = C_ACT;
    else if (r < 46) c = C_WR;
    else if (r < 63) c = C_RD;
    else if (r < 78) c = C_PRE;
    else if (r < 84) c = C_REF;
    else if (r < 88) c = C_ZQCL;
    else if (r < 91) c = C_MRS;
    else             c = C_NOP;
    a = 15'($urandom);
    a[10] = ($urandom_range(0, 3) == 0);
    a[4:3] = 2'b00;
    applyStimulus(c, 3'($urandom_range(0, 3)), a, 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Directed scenarios first, then randomized traffic
  initial begin
    int strobes;
    int first_s;
    int last_s;
    int busy_cnt;
    for (int i = 0; i < 256; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 2'b00;
    end
    cyc = 0;
    modelReset();
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    checkOutput();
    check("init_ready", 32'(ready), 32'd0);

    // Commands before ZQCL are rejected; ZQCL brings the controller up
    applyStimulus(C_ACT, 3'd0, 15'd0, 16'd0, 1'b0, 1'b0);
    check("pre_zq_err_code", 32'(err_code), 32'd5);
    check("pre_zq_err_count", 32'(err_count), 32'd1);
    applyStimulus(C_MRS, 3'd0, 15'd0, 16'd0, 1'b0, 1'b0);
    applyStimulus(C_ZQCL, 3'd0, 15'd0, 16'd0, 1'b0, 1'b0);
    check("zq_ready", 32'(ready), 32'd1);

    // Basic write and read with CL latency
    applyStimulus(C_ACT, 3'd2, 15'h0011, 16'd0, 1'b0, 1'b0);
    applyStimulus(C_WR, 3'd2, 15'd3, 16'hA5C3, 1'b0, 1'b0);
    applyStimulus(C_RD, 3'd2, 15'd3, 16'd0, 1'b0, 1'b0);
    for (int i = 1; i < CL; i++) begin
      nop(1);
      check("rd_early", 32'(DQ_rd_valid), 32'd0);
    end
    nop(1);
    check("rd_on_time", 32'(DQ_rd_valid), 32'd1);
    check("rd_word", 32'(DQ_rd), 32'hA5C3);

    // Upper byte masked on the second write
    applyStimulus(C_WR, 3'd2, 15'd3, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(C_WR, 3'd2, 15'd3, 16'h1200, 1'b0, 1'b1);
    applyStimulus(C_RD, 3'd2, 15'd3, 16'd0, 1'b0, 1'b0);
    nop(CL);
    check("masked_word", 32'(DQ_rd), 32'hFF00);

    // Auto-precharge read closes the bank; next read is refused
    applyStimulus(C_RD, 3'd2, 15'h0403, 16'd0, 1'b0, 1'b0);
    check("ap_closed", 32'(bank_open[2]), 32'd0);
    applyStimulus(C_RD, 3'd2, 15'd3, 16'd0, 1'b0, 1'b0);
    check("closed_rd_code", 32'(err_code), 32'd2);
    strobes = 0;
    for (int i = 0; i < CL + 2; i++) begin
      nop(1);
      if (DQ_rd_valid) strobes++;
    end
    check("closed_rd_strobes", 32'(strobes), 32'd1);

    // Refresh rules and busy window
    applyStimulus(C_ACT, 3'd1, 15'h0022, 16'd0, 1'b0, 1'b0);
    applyStimulus(C_REF, 3'd0, 15'd0, 16'd0, 1'b0, 1'b0);
    check("ref_open_code", 32'(err_code), 32'd3);
    applyStimulus(C_PRE, 3'd0, 15'h0400, 16'd0, 1'b0, 1'b0);
    check("pre_all", 32'(bank_open), 32'd0);
    applyStimulus(C_REF, 3'd0, 15'd0, 16'd0, 1'b0, 1'b0);
    busy_cnt = refresh_busy ? 1 : 0;
    for (int i = 1; i <= TRFC + 2; i++) begin
      if (i == 3) begin
        applyStimulus(C_ACT, 3'd0, 15'd0, 16'd0, 1'b0, 1'b0);
        check("ref_busy_code", 32'(err_code), 32'd4);
      end else begin
        nop(1);
      end
      if (refresh_busy) busy_cnt++;
    end
    check("ref_busy_cycles", 32'(busy_cnt), 32'(TRFC));
    check("ref_done_ready", 32'(ready), 32'd1);

    // Four back-to-back reads give four consecutive strobes
    applyStimulus(C_ACT, 3'd2, 15'h0011, 16'd0, 1'b0, 1'b0);
    strobes = 0;
    first_s = -1;
    last_s  = -1;
    for (int i = 0; i < 4 + CL + 3; i++) begin
      if (i < 4) applyStimulus(C_RD, 3'd2, 15'(i), 16'd0, 1'b0, 1'b0);
      else       nop(1);
      if (DQ_rd_valid) begin
        strobes++;
        if (first_s < 0) first_s = i;
        last_s = i;
      end
    end
    check("b2b_strobes", 32'(strobes), 32'd4);
    check("b2b_span", 32'(last_s - first_s), 32'd3);

    // Reset in flight drops pending reads
    applyStimulus(C_RD, 3'd2, 15'd3, 16'd0, 1'b0, 1'b0);
    applyStimulus(C_RD, 3'd2, 15'd2, 16'd0, 1'b0, 1'b0);
    doReset();
    strobes = 0;
    for (int i = 0; i < CL + 5; i++) begin
      nop(1);
      if (DQ_rd_valid) strobes++;
    end
    check("post_reset_strobes", 32'(strobes), 32'd0);

    // Randomized traffic with occasional resets
    applyStimulus(C_ZQCL, 3'd0, 15'd0, 16'd0, 1'b0, 1'b0);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      else randomCycle();
    end
    nop(CL + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
